// File: rtl/ife_pkg.sv
// Shared widths, constants and helpers for the instruction-block expander.
// Helpers work on a fixed maximum-width mask so that any parameter set can use them.
package ife_pkg;

  localparam int INSTR_W = 32;
  localparam int ID_W    = 7;
  localparam logic [31:0] IFE_NOP = 32'h00000013;
  localparam int IFE_MAX_SLOTS = 64;

  // Right-shift amount that brings slot idx of an MSB-first packed block down to bit 0.
  function automatic int slot_shift(input int idx, input int n_slots, input int w);
    return (n_slots - 1 - idx) * w;
  endfunction

  // Lowest group index >= start with a non-zero mask slice; n_groups when none exists.
  function automatic int first_group(input logic [IFE_MAX_SLOTS-1:0] mask,
                                     input int issue_w, input int n_groups, input int start);
    logic [IFE_MAX_SLOTS-1:0] lane_m;
    logic [IFE_MAX_SLOTS-1:0] sh;
    int                       res;
    lane_m = (IFE_MAX_SLOTS'(1) << issue_w) - IFE_MAX_SLOTS'(1);
    res    = n_groups;
    for (int g = n_groups - 1; g >= 0; g--) begin
      sh = mask >> (g * issue_w);
      if (g >= start && (sh & lane_m) != '0) res = g;
    end
    return res;
  endfunction

endpackage

// File: rtl/ife_block_fifo.sv
// Block queue: DEPTH entries of {data, id, mask} with wrapping pointers and occupancy count.
// Flush clears pointers and count and overrides any push or pop in the same cycle.
module ife_block_fifo
  import ife_pkg::*;
#(
  parameter int DW    = 128,
  parameter int IW    = 7,
  parameter int MW    = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] wid_i,
  input  logic [MW-1:0] wmask_i,
  output logic [DW-1:0] rdata_o,
  output logic [IW-1:0] rid_o,
  output logic [MW-1:0] rmask_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] data_q [DEPTH];
  logic [IW-1:0] id_q   [DEPTH];
  logic [MW-1:0] mask_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wptr_q] <= wdata_i;
      id_q[wptr_q]   <= wid_i;
      mask_q[wptr_q] <= wmask_i;
    end
  end

  assign rdata_o = data_q[rptr_q];
  assign rid_o   = id_q[rptr_q];
  assign rmask_o = mask_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ife_block_expander.sv
// Instruction-block expander: queues masked blocks and issues them as ISSUE_W-wide groups,
// skipping empty groups and tagging each lane with its slot index.
module ife_block_expander
  import ife_pkg::*;
#(
  parameter int INSTR_W      = ife_pkg::INSTR_W,
  parameter int BLOCK_INSTRS = 4,
  parameter int ISSUE_W      = 2,
  parameter int ID_W         = ife_pkg::ID_W,
  parameter int DEPTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    block_valid_in,
  output logic                                    block_ready_out,
  input  logic [BLOCK_INSTRS*INSTR_W-1:0]         block_data_in,
  input  logic [ID_W-1:0]                         block_id_in,
  input  logic [BLOCK_INSTRS-1:0]                 block_mask_in,
  input  logic                                    flush_in,
  output logic [ISSUE_W-1:0]                      issue_valid_out,
  output logic [ISSUE_W*INSTR_W-1:0]              issue_instr_out,
  output logic [ISSUE_W*$clog2(BLOCK_INSTRS)-1:0] issue_slot_out,
  output logic [ID_W-1:0]                         issue_id_out,
  output logic                                    issue_last_out,
  input  logic                                    issue_ready_in,
  output logic [$clog2(DEPTH):0]                  count_out
);

  localparam int DW      = BLOCK_INSTRS * INSTR_W;
  localparam int SW      = $clog2(BLOCK_INSTRS);
  localparam int NGROUPS = BLOCK_INSTRS / ISSUE_W;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [DW-1:0]           head_data;
  logic [ID_W-1:0]         head_id;
  logic [BLOCK_INSTRS-1:0] head_mask;
  logic [CNT_W-1:0]        count;
  logic                    full, empty;

  logic [GW-1:0] cursor_q, cursor_d;
  int            disp;
  logic          head_ok;
  logic          is_last;
  logic          fifo_push, issue_fire, fifo_pop;

  assign block_ready_out = !rst && !flush_in && !full;
  assign fifo_push       = block_valid_in && block_ready_out && (|block_mask_in);
  assign issue_fire      = (|issue_valid_out) && issue_ready_in && !flush_in;
  assign fifo_pop        = issue_fire && is_last;

  ife_block_fifo #(
    .DW    (DW),
    .IW    (ID_W),
    .MW    (BLOCK_INSTRS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (flush_in),
    .wdata_i (block_data_in),
    .wid_i   (block_id_in),
    .wmask_i (block_mask_in),
    .rdata_o (head_data),
    .rid_o   (head_id),
    .rmask_o (head_mask),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Current group and whether any later group of the head block still carries work.
  always_comb begin
    disp    = first_group(IFE_MAX_SLOTS'(head_mask), ISSUE_W, NGROUPS, int'(cursor_q));
    head_ok = !empty && (disp < NGROUPS);
    is_last = first_group(IFE_MAX_SLOTS'(head_mask), ISSUE_W, NGROUPS, disp + 1) >= NGROUPS;
  end

  always_comb begin
    cursor_d = cursor_q;
    if (flush_in) begin
      cursor_d = '0;
    end else if (issue_fire) begin
      cursor_d = is_last ? '0 : GW'(disp + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_q <= '0;
    end else begin
      cursor_q <= cursor_d;
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    int                      lane_slot;
    logic [BLOCK_INSTRS-1:0] mask_sh;
    logic [DW-1:0]           data_sh;
    logic                    lane_vld;
    logic [INSTR_W-1:0]      lane_instr;
    logic [SW-1:0]           lane_idx;

    always_comb begin
      lane_slot  = disp * ISSUE_W + k;
      mask_sh    = head_mask >> lane_slot;
      data_sh    = head_data >> slot_shift(lane_slot, BLOCK_INSTRS, INSTR_W);
      lane_vld   = head_ok && mask_sh[0];
      lane_instr = lane_vld ? data_sh[INSTR_W-1:0] : '0;
      lane_idx   = lane_vld ? SW'(lane_slot) : '0;
    end

    assign issue_valid_out[k]                            = lane_vld;
    assign issue_instr_out[(ISSUE_W-1-k)*INSTR_W +: INSTR_W] = lane_instr;
    assign issue_slot_out[(ISSUE_W-1-k)*SW +: SW]          = lane_idx;
  end

  assign issue_id_out   = head_ok ? head_id : '0;
  assign issue_last_out = head_ok && is_last;
  assign count_out      = count;

endmodule

// File: tb/tb_ife_block_expander.sv
// Directed bench for ife_block_expander: a vector table for single-cycle behaviour plus
// hand-written sequences for full queue, flush and asynchronous reset.
module tb_ife_block_expander;

  localparam logic [31:0] I0 = 32'h00500513;
  localparam logic [31:0] I1 = 32'h00520293;
  localparam logic [31:0] I2 = 32'h00600593;
  localparam logic [31:0] I3 = 32'h00628313;

  logic         clk = 1'b0;
  logic         rst;
  logic         block_valid_in;
  logic         block_ready_out;
  logic [127:0] block_data_in;
  logic [6:0]   block_id_in;
  logic [3:0]   block_mask_in;
  logic         flush_in;
  logic [1:0]   issue_valid_out;
  logic [63:0]  issue_instr_out;
  logic [3:0]   issue_slot_out;
  logic [6:0]   issue_id_out;
  logic         issue_last_out;
  logic         issue_ready_in;
  logic [2:0]   count_out;

  int n_vec = 0;
  int n_err = 0;

  ife_block_expander dut (
    .clk             (clk),
    .rst             (rst),
    .block_valid_in  (block_valid_in),
    .block_ready_out (block_ready_out),
    .block_data_in   (block_data_in),
    .block_id_in     (block_id_in),
    .block_mask_in   (block_mask_in),
    .flush_in        (flush_in),
    .issue_valid_out (issue_valid_out),
    .issue_instr_out (issue_instr_out),
    .issue_slot_out  (issue_slot_out),
    .issue_id_out    (issue_id_out),
    .issue_last_out  (issue_last_out),
    .issue_ready_in  (issue_ready_in),
    .count_out       (count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bv;
    logic [6:0]  id;
    logic [3:0]  mask;
    logic        rdy;
    logic [1:0]  e_valid;
    logic [63:0] e_instr;
    logic [3:0]  e_slot;
    logic [6:0]  e_id;
    logic        e_last;
    logic [2:0]  e_cnt;
    logic        e_brdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit bv, input int id, input int mask, input bit rdy,
                              input int ev, input logic [63:0] ei, input int es,
                              input int eid, input bit el, input int ec, input bit eb);
    vec_t v;
    v.bv = bv; v.id = 7'(id); v.mask = 4'(mask); v.rdy = rdy;
    v.e_valid = 2'(ev); v.e_instr = ei; v.e_slot = 4'(es); v.e_id = 7'(eid);
    v.e_last = el; v.e_cnt = 3'(ec); v.e_brdy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_group(input string nm, input int ev, input logic [63:0] ei, input int es,
                           input int eid, input bit el, input int ec);
    chk({nm, ".valid"}, 64'(issue_valid_out), 64'(ev));
    chk({nm, ".instr"}, issue_instr_out, ei);
    chk({nm, ".slot"},  64'(issue_slot_out), 64'(es));
    chk({nm, ".id"},    64'(issue_id_out), 64'(eid));
    chk({nm, ".last"},  64'(issue_last_out), 64'(el));
    chk({nm, ".count"}, 64'(count_out), 64'(ec));
  endtask

  task automatic push_in(input bit bv, input int id, input int mask);
    block_valid_in = bv;
    block_id_in    = 7'(id);
    block_mask_in  = 4'(mask);
  endtask

  initial begin
    rst            = 1'b1;
    block_valid_in = 1'b0;
    block_data_in  = {I0, I1, I2, I3};
    block_id_in    = '0;
    block_mask_in  = '0;
    flush_in       = 1'b0;
    issue_ready_in = 1'b1;

    //            bv id m    rdy ev instr          slot   id last cnt brdy
    vecs.push_back(mk(1, 1, 'hF, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 3, {I0, I1},       'h1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 3, {I2, I3},       'hB, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2, 'hC, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 3, {I2, I3},       'hB, 2, 1, 1, 1));
    vecs.push_back(mk(1, 3, 'h5, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 1, {I0, 32'h0},    'h0, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 1, {I2, 32'h0},    'h8, 3, 1, 1, 1));
    vecs.push_back(mk(1, 4, 'hA, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 2, {32'h0, I1},    'h1, 4, 0, 1, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 2, {32'h0, I3},    'h3, 4, 1, 1, 1));
    vecs.push_back(mk(1, 5, 'h0, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6, 'hF, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 7, 'h3, 1, 3, {I0, I1},       'h1, 6, 0, 1, 1));
    vecs.push_back(mk(1, 8, 'h8, 1, 3, {I2, I3},       'hB, 6, 1, 2, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 3, {I0, I1},       'h1, 7, 1, 2, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 2, {32'h0, I3},    'h3, 8, 1, 1, 1));
    vecs.push_back(mk(0, 0, 'h0, 1, 0, 64'h0,          'h0, 0, 0, 0, 1));

    #3;
    chk("rst.ready", 64'(block_ready_out), 64'd0);
    chk_group("rst", 0, 64'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;

    foreach (vecs[i]) begin
      push_in(vecs[i].bv, int'(vecs[i].id), int'(vecs[i].mask));
      issue_ready_in = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d", i), 64'(issue_valid_out), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d.instr", i), issue_instr_out, vecs[i].e_instr);
      chk($sformatf("v%0d.slot", i), 64'(issue_slot_out), 64'(vecs[i].e_slot));
      chk($sformatf("v%0d.id", i), 64'(issue_id_out), 64'(vecs[i].e_id));
      chk($sformatf("v%0d.last", i), 64'(issue_last_out), 64'(vecs[i].e_last));
      chk($sformatf("v%0d.count", i), 64'(count_out), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d.bready", i), 64'(block_ready_out), 64'(vecs[i].e_brdy));
      tick();
    end

    // Full queue: five offers with downstream stalled, only four accepted.
    issue_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_in(1, i + 1, 'hF);
      #1;
      chk($sformatf("full.bready%0d", i), 64'(block_ready_out), 64'(i < 4));
      tick();
    end
    push_in(0, 0, 0);
    #1;
    chk_group("full.hold0", 3, {I0, I1}, 'h1, 1, 0, 4);
    tick();
    chk_group("full.hold1", 3, {I0, I1}, 'h1, 1, 0, 4);
    issue_ready_in = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      for (int g = 0; g < 2; g++) begin
        #1;
        chk_group($sformatf("drain.b%0d.g%0d", b, g), 3,
                  (g == 0) ? {I0, I1} : {I2, I3}, (g == 0) ? 'h1 : 'hB, b, g == 1, 5 - b);
        if (b == 1 && g == 0) chk("drain.bready_full", 64'(block_ready_out), 64'd0);
        if (b == 2 && g == 0) chk("drain.bready_back", 64'(block_ready_out), 64'd1);
        tick();
      end
    end
    #1;
    chk_group("drain.empty", 0, 64'h0, 0, 0, 0, 0);

    // Flush with a concurrent push after one group of block 1 has issued.
    issue_ready_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_in(1, i, 'hF);
      tick();
    end
    push_in(0, 0, 0);
    issue_ready_in = 1'b1;
    #1;
    chk_group("flush.pre", 3, {I0, I1}, 'h1, 1, 0, 3);
    tick();
    issue_ready_in = 1'b0;
    flush_in       = 1'b1;
    push_in(1, 9, 'hF);
    #1;
    chk_group("flush.mid", 3, {I2, I3}, 'hB, 1, 1, 3);
    chk("flush.bready", 64'(block_ready_out), 64'd0);
    tick();
    flush_in = 1'b0;
    push_in(0, 0, 0);
    #1;
    chk_group("flush.post", 0, 64'h0, 0, 0, 0, 0);
    tick();
    chk_group("flush.post2", 0, 64'h0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a block with two queued.
    issue_ready_in = 1'b0;
    push_in(1, 'h0A, 'hF);
    tick();
    push_in(1, 'h0B, 'hF);
    tick();
    push_in(0, 0, 0);
    issue_ready_in = 1'b1;
    #1;
    chk_group("ar.pre", 3, {I0, I1}, 'h1, 'h0A, 0, 2);
    tick();
    issue_ready_in = 1'b0;
    #1;
    chk_group("ar.mid", 3, {I2, I3}, 'hB, 'h0A, 1, 2);
    rst = 1'b1;
    #1;
    chk_group("ar.rst", 0, 64'h0, 0, 0, 0, 0);
    chk("ar.bready", 64'(block_ready_out), 64'd0);
    tick();
    rst = 1'b0;
    issue_ready_in = 1'b1;
    push_in(1, 'h0C, 'hF);
    #1;
    chk("ar.count0", 64'(count_out), 64'd0);
    tick();
    push_in(0, 0, 0);
    #1;
    chk_group("ar.fresh", 3, {I0, I1}, 'h1, 'h0C, 0, 1);
    tick();
    chk_group("ar.fresh1", 3, {I2, I3}, 'hB, 'h0C, 1, 1);
    tick();
    chk_group("ar.done", 0, 64'h0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
